song_sequencer: RTL and testbench

Parametrised song sequencer. Walks a note/duration table in an external synchronous song ROM and presents one note at a time to the note player, advancing on the player's note_done. It adds several features:
- configurable song count, song length, field widths and ROM read latency
- loop mode
- restart
- mid-song song change
- an in-table end-of-song marker
It sits between the user controls and the note player / ROM.

---
 rtl/song_sequencer_pkg.sv | 26 ++
 rtl/song_sequencer_if.sv | 37 +++
 rtl/song_sequencer_song_index_counter.sv | 46 ++++
 rtl/song_sequencer.sv | 143 ++++++++++++++
 tb/tb_song_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding,
// a constant-foldable ceil(log2) helper and the ROM word field layout.
package song_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ROM word is {note, duration}: duration sits in the LSBs, note above it.
    localparam int DUR_LSB = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int note_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Bundle of user controls, note-player handshake and song ROM bus.
// master = sequencer side, slave = environment (controls, player, ROM).
interface song_sequencer_if
    import song_sequencer_pkg::*;
#(
    parameter int NUM_SONGS      = 4,
    parameter int NOTES_PER_SONG = 32,
    parameter int NOTE_W         = 6,
    parameter int DUR_W          = 6
);
    localparam int SONG_W = clog2(NUM_SONGS);
    localparam int IDX_W  = clog2(NOTES_PER_SONG);

    logic                      play;
    logic                      loop;
    logic                      restart;
    logic [SONG_W-1:0]         song;
    logic                      note_done;
    logic [SONG_W+IDX_W-1:0]   rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic [NOTE_W-1:0]         note;
    logic [DUR_W-1:0]          duration;
    logic                      new_note;
    logic                      song_done;
    logic [IDX_W-1:0]          note_index;

    modport master (
        input  play, loop, restart, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done, note_index
    );

    modport slave (
        output play, loop, restart, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done, note_index
    );

endinterface

// File: rtl/song_sequencer_song_index_counter.sv
// Song/entry position tracker: latches the selected song, walks the
// entry index, flags the last entry and forms the ROM address.
module song_index_counter
    import song_sequencer_pkg::*;
#(
    parameter int NUM_SONGS      = 4,
    parameter int NOTES_PER_SONG = 32,
    localparam int SONG_W        = clog2(NUM_SONGS),
    localparam int IDX_W         = clog2(NOTES_PER_SONG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SONG_W-1:0]       i_song,
    input  logic                    i_load,
    input  logic                    i_advance,
    output logic                    o_song_change,
    output logic                    o_is_last,
    output logic [IDX_W-1:0]        o_index,
    output logic [SONG_W+IDX_W-1:0] o_rom_addr
);

    logic [SONG_W-1:0] r_song_q;
    logic [IDX_W-1:0]  r_index;
    logic              w_is_last;

    assign w_is_last     = (r_index == IDX_W'(NOTES_PER_SONG - 1));
    assign o_is_last     = w_is_last;
    assign o_song_change = (i_song != r_song_q);
    assign o_index       = r_index;
    assign o_rom_addr    = {r_song_q, r_index};

    // Load a new song at entry 0, or step the index; the last entry only
    // wraps when the FSM asks to advance from it (loop mode).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_song_q <= '0;
            r_index  <= '0;
        end else if (i_load) begin
            r_song_q <= i_song;
            r_index  <= '0;
        end else if (i_advance) begin
            r_index  <= w_is_last ? '0 : r_index + 1'b1;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the note/duration table of the selected song in
// an external synchronous ROM and hands one note at a time to the player.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int NUM_SONGS      = 4,
    parameter int NOTES_PER_SONG = 32,
    parameter int NOTE_W         = 6,
    parameter int DUR_W          = 6,
    parameter int ROM_LATENCY    = 1
) (
    input  logic               clk,
    input  logic               reset,
    song_sequencer_if.master   bus
);

    // Fetch spends one cycle presenting the address plus ROM_LATENCY cycles
    // waiting for the data, so the counter runs 0..ROM_LATENCY.
    localparam int LAT_W    = clog2(ROM_LATENCY + 1);
    localparam int NOTE_LSB = note_lsb(DUR_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [LAT_W-1:0]  w_lat_nxt;
    logic [NOTE_W-1:0] r_note;
    logic [DUR_W-1:0]  r_duration;
    logic              r_new_note;
    logic              w_new_note_nxt;
    logic              w_capture;
    logic              w_advance;
    logic              w_load;
    logic              w_song_change;
    logic              w_is_last;
    logic [NOTE_W-1:0] w_rom_note;
    logic [DUR_W-1:0]  w_rom_dur;

    assign w_rom_dur  = bus.rom_data[DUR_LSB +: DUR_W];
    assign w_rom_note = bus.rom_data[NOTE_LSB +: NOTE_W];
    assign w_load     = bus.restart | w_song_change;

    song_index_counter #(
        .NUM_SONGS      (NUM_SONGS),
        .NOTES_PER_SONG (NOTES_PER_SONG)
    ) u_index (
        .clk           (clk),
        .rst           (reset),
        .i_song        (bus.song),
        .i_load        (w_load),
        .i_advance     (w_advance),
        .o_song_change (w_song_change),
        .o_is_last     (w_is_last),
        .o_index       (bus.note_index),
        .o_rom_addr    (bus.rom_addr)
    );

    assign bus.note      = r_note;
    assign bus.duration  = r_duration;
    assign bus.new_note  = r_new_note;
    assign bus.song_done = (r_state == ST_DONE);

    // Next-state logic: restart/song change overrides everything, then the
    // per-state rules for play and note_done.
    always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat_cnt;
        w_capture      = 1'b0;
        w_new_note_nxt = 1'b0;
        w_advance      = 1'b0;
        if (w_load) begin
            w_state_nxt = ST_PAUSE;
            w_lat_nxt   = '0;
        end else begin
            case (r_state)
                ST_PAUSE: begin
                    if (bus.play) begin
                        w_state_nxt = ST_FETCH;
                        w_lat_nxt   = '0;
                    end
                end
                ST_FETCH: begin
                    if (!bus.play) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (r_lat_cnt == LAT_W'(ROM_LATENCY)) begin
                        // A zero duration is the end-of-song marker.
                        if (w_rom_dur != '0) begin
                            w_state_nxt    = ST_OUTPUT;
                            w_capture      = 1'b1;
                            w_new_note_nxt = 1'b1;
                        end else begin
                            w_state_nxt    = ST_DONE;
                        end
                    end else begin
                        w_lat_nxt = r_lat_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    // A started note always runs to note_done, even when paused.
                    if (bus.note_done) begin
                        if (!w_is_last || bus.loop) begin
                            w_advance   = 1'b1;
                            w_state_nxt = bus.play ? ST_FETCH : ST_PAUSE;
                            w_lat_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_PAUSE;
                end
            endcase
        end
    end

    // State, latency counter and new_note strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_PAUSE;
            r_lat_cnt  <= '0;
            r_new_note <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat_cnt  <= w_lat_nxt;
            r_new_note <= w_new_note_nxt;
        end
    end

    // Note/duration output registers, loaded only on a real (non-marker) fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_note     <= '0;
            r_duration <= '0;
        end else if (w_capture) begin
            r_note     <= w_rom_note;
            r_duration <= w_rom_dur;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer: synchronous ROM model with latency,
// directed scenarios and a random phase, all scored against a
// transaction-level reference model.
module tb_song_sequencer;

    localparam int NS  = 4;
    localparam int NP  = 32;
    localparam int NW  = 6;
    localparam int DW  = 6;
    localparam int LAT = 3;

    localparam int P_PAUSE = 0;
    localparam int P_FETCH = 1;
    localparam int P_PLAY  = 2;
    localparam int P_DONE  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    song_sequencer_if #(
        .NUM_SONGS(NS), .NOTES_PER_SONG(NP), .NOTE_W(NW), .DUR_W(DW)
    ) bus ();

    song_sequencer #(
        .NUM_SONGS(NS), .NOTES_PER_SONG(NP), .NOTE_W(NW), .DUR_W(DW),
        .ROM_LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous ROM with LAT cycles of read latency.
    logic [NW+DW-1:0] rom_mem  [NS*NP];
    logic [NW+DW-1:0] rom_pipe [LAT];

    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[bus.rom_addr];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_data = rom_pipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: where in the song we are and what the player sees.
    int m_song, m_idx, m_phase, m_cnt, m_note, m_dur;
    bit m_new;

    bit auto_nd;
    int nd_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_song = 0; m_idx = 0; m_phase = P_PAUSE; m_cnt = 0;
        m_note = 0; m_dur = 0; m_new = 0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step();
        logic [NW+DW-1:0] entry;
        m_new = 0;
        if (bus.restart || int'(bus.song) != m_song) begin
            m_song  = int'(bus.song);
            m_idx   = 0;
            m_phase = P_PAUSE;
        end else begin
            case (m_phase)
                P_PAUSE: if (bus.play) begin m_phase = P_FETCH; m_cnt = 0; end
                P_FETCH: begin
                    if (!bus.play) m_phase = P_PAUSE;
                    else if (m_cnt < LAT) m_cnt++;
                    else begin
                        entry = rom_mem[m_song*NP + m_idx];
                        if (entry[DW-1:0] != 0) begin
                            m_note  = int'(entry[NW+DW-1:DW]);
                            m_dur   = int'(entry[DW-1:0]);
                            m_new   = 1;
                            m_phase = P_PLAY;
                        end else m_phase = P_DONE;
                    end
                end
                P_PLAY: if (bus.note_done) begin
                    if (m_idx < NP-1 || bus.loop) begin
                        m_idx   = (m_idx + 1) % NP;
                        m_phase = bus.play ? P_FETCH : P_PAUSE;
                        m_cnt   = 0;
                    end else m_phase = P_DONE;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("new_note",   32'(bus.new_note),   32'(m_new));
        chk("note",       32'(bus.note),       32'(m_note));
        chk("duration",   32'(bus.duration),   32'(m_dur));
        chk("song_done",  32'(bus.song_done),  32'(m_phase == P_DONE));
        chk("note_index", 32'(bus.note_index), 32'(m_idx));
        chk("rom_addr",   32'(bus.rom_addr),   32'(m_song*NP + m_idx));
    endtask

    // Advance one clock, score it, and let the player model react.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (auto_nd) begin
            bus.note_done = 1'b0;
            if (bus.new_note) nd_cnt = 3;
            else if (nd_cnt > 0) begin
                nd_cnt--;
                if (nd_cnt == 0) bus.note_done = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, lat, prev_note;
        bit sd_seen;

        for (int i = 0; i < NP; i++) begin
            rom_mem[0*NP+i] = {NW'(i+1), DW'(4)};
            rom_mem[1*NP+i] = {NW'((i*3+7) % 64), DW'(i%5 + 1)};
            rom_mem[2*NP+i] = (i == 5) ? '0 : {NW'(i+10), DW'(2)};
            rom_mem[3*NP+i] = (NW+DW)'($urandom);
        end
        rom_mem[3*NP+20][DW-1:0] = '0;

        auto_nd = 0; nd_cnt = 0;
        bus.play = 0; bus.loop = 0; bus.restart = 0; bus.song = '0; bus.note_done = 0;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // 1: full song, no loop
        bus.play = 1; auto_nd = 1; cnt = 0;
        for (int c = 0; c < 1500 && !bus.song_done; c++) begin
            tick();
            if (bus.new_note) cnt++;
        end
        chk("t1_notes", 32'(cnt), 32);
        chk("t1_done", 32'(bus.song_done), 1);
        repeat (20) begin tick(); if (bus.new_note) cnt++; end
        chk("t1_after", 32'(cnt), 32);

        // 2: loop mode over 70 notes
        bus.restart = 1; tick(); bus.restart = 0;
        bus.loop = 1; cnt = 0; sd_seen = 0; prev_note = 0;
        for (int c = 0; c < 2000 && cnt < 70; c++) begin
            tick();
            if (bus.song_done) sd_seen = 1;
            if (bus.new_note) begin
                cnt++;
                if (prev_note == 32) chk("t2_wrap", 32'(bus.note), 1);
                prev_note = int'(bus.note);
            end
        end
        chk("t2_notes", 32'(cnt), 70);
        chk("t2_sd", 32'(sd_seen), 0);

        // 3: fetch latency and pause in the middle of a fetch
        auto_nd = 0; bus.note_done = 0; bus.loop = 0; bus.play = 0;
        bus.restart = 1; tick(); bus.restart = 0;
        repeat (3) tick();
        bus.play = 1; lat = 0;
        for (int c = 0; c < 20; c++) begin
            tick(); lat++;
            if (bus.new_note) break;
        end
        chk("t3_lat", 32'(lat), 32'(LAT+2));
        bus.note_done = 1; tick(); bus.note_done = 0;
        cnt = 0;
        tick(); if (bus.new_note) cnt++;
        bus.play = 0;
        repeat (6) begin tick(); if (bus.new_note) cnt++; end
        chk("t3_nonew", 32'(cnt), 0);
        chk("t3_idx", 32'(bus.note_index), 1);

        // 4: end-of-song marker at song 2 entry 5
        bus.song = 2; bus.play = 1; auto_nd = 1; nd_cnt = 0; cnt = 0;
        for (int c = 0; c < 1000 && !bus.song_done; c++) begin
            tick();
            if (bus.new_note) cnt++;
        end
        repeat (10) begin tick(); if (bus.new_note) cnt++; end
        chk("t4_notes", 32'(cnt), 5);
        chk("t4_done", 32'(bus.song_done), 1);
        chk("t4_note", 32'(bus.note), 14);
        chk("t4_dur", 32'(bus.duration), 2);

        // 5: song change coinciding with note_done at index 10
        bus.song = 0; nd_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (bus.new_note && bus.note_index == 10) break;
        end
        chk("t5_reach", 32'(bus.note_index), 10);
        auto_nd = 0;
        bus.song = 1; bus.note_done = 1; tick(); bus.note_done = 0;
        chk("t5_idx", 32'(bus.note_index), 0);
        chk("t5_addr", 32'(bus.rom_addr), 32'(NP));
        for (int c = 0; c < 50; c++) begin
            tick();
            if (bus.new_note) break;
        end
        chk("t5_note", 32'(bus.note), 7);

        // 6: asynchronous reset while a note is playing
        auto_nd = 1; nd_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.new_note) break;
        end
        auto_nd = 0; bus.note_done = 0; bus.song = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            tick(); lat++;
            if (bus.new_note) break;
        end
        chk("t6_lat", 32'(lat), 32'(LAT+2));
        chk("t6_note", 32'(bus.note), 1);

        // 7: random controls against the model
        for (int c = 0; c < 3000; c++) begin
            bus.play      = ($urandom % 8) != 0;
            if ($urandom % 200 == 0) bus.loop = ~bus.loop;
            bus.restart   = ($urandom % 64) == 0;
            if ($urandom % 100 == 0) bus.song = 2'($urandom % NS);
            bus.note_done = ($urandom % 4) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
